infra_reset_sequencer: RTL
==========================

INFRA_RESET_SEQUENCER -- requirements
Module: infra_reset_sequencer

Interface
REQ-001 Parameter NUM_CH, 4, number of reset channels (1..8).
REQ-002 Parameter SYNC_STAGES, 3, synchroniser depth for pll_lock and idelay_rdy (2..6).
REQ-003 Parameter HOLD_CYCLES, 65535, post-lock hold before IDELAY reset release (1..2^24-1).
REQ-004 Parameter IDLY_RST_CYCLES, 16, idelay_rst extension after HOLD (1..255).
REQ-005 Parameter RDY_TIMEOUT, 4096, max cycles waiting for idelay_rdy (1..2^16-1).
REQ-006 Parameter STAGGER, 8, cycles between successive channel releases (0..255).
REQ-007 Parameter SOFT_CYCLES, 32, soft-reset assertion length (1..255).
REQ-008 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-009 sys_rst_n  in  1  reset; synchronous, active-low.
REQ-010 pll_lock  in  1  MMCM lock, asynchronous.
REQ-011 idelay_rdy  in  1  IDELAYCTRL ready, asynchronous.
REQ-012 soft_rst  in  1  synchronous single-cycle soft-reset request.
REQ-013 ch_mask  in  NUM_CH  channels affected by soft_rst (1 = affected).
REQ-014 ch_rst  out  NUM_CH  per-channel reset, active-high, registered.
REQ-015 idelay_rst  out  1  IDELAYCTRL reset, active-high, registered.
REQ-016 all_ready  out  1  high only in RUN.
REQ-017 state  out  3  FSM encoding: WAIT_LOCK=0, HOLD=1, IDLY_RST=2, WAIT_RDY=3, RELEASE=4, RUN=5, SOFT=6.
REQ-018 timeout_err  out  1  sticky: idelay_rdy timeout occurred.
REQ-019 lock_loss_cnt  out  8  saturating count of lock losses.

Function
REQ-020 pll_lock and idelay_rdy SHALL each pass SYNC_STAGES flops; lock_s/rdy_s denote the synchroniser outputs.
REQ-021 WAIT_LOCK: ch_rst all 1, idelay_rst 1; go HOLD on first cycle lock_s=1, counter cleared.
REQ-022 HOLD: idelay_rst 1; stay exactly HOLD_CYCLES cycles, then IDLY_RST.
REQ-023 IDLY_RST: idelay_rst 1 for exactly IDLY_RST_CYCLES cycles, then WAIT_RDY; idelay_rst 0 from WAIT_RDY onward.
REQ-024 WAIT_RDY: go RELEASE on first cycle rdy_s=1; if RDY_TIMEOUT cycles elapse without rdy_s, set timeout_err and go RELEASE.
REQ-025 RELEASE: counter c starts at 0 on entry, increments per cycle; when c == i*STAGGER, ch_rst[i] SHALL clear on the following edge; after c == (NUM_CH-1)*STAGGER go RUN.
REQ-026 STAGGER=0: all channels clear together one cycle after RELEASE entry.
REQ-027 RUN: all_ready 1; soft_rst=1 with ch_mask!=0 sets ch_rst for masked channels, all_ready 0, state SOFT on next edge.
REQ-028 soft_rst ignored outside RUN and when ch_mask==0; unmasked channels SHALL remain 0 throughout SOFT/RELEASE.
REQ-029 SOFT: hold SOFT_CYCLES cycles, then RELEASE using REQ-025 schedule; idelay_rst stays 0.
REQ-030 Any state except WAIT_LOCK, lock_s=0: next edge enter WAIT_LOCK, ch_rst all 1, idelay_rst 1, all_ready 0, counters cleared; takes priority over soft_rst and all transitions.
REQ-031 lock_loss_cnt SHALL increment on each lock_s 1->0 transition, saturating at 255.
REQ-032 timeout_err SHALL clear only on reset; not cleared by lock loss.
REQ-033 Counters SHALL be sized by $clog2 of largest required count; no wrap in any state.

Reset
REQ-034 sys_rst_n=0 at an edge: state WAIT_LOCK, ch_rst all 1, idelay_rst 1, all_ready 0, timeout_err 0, lock_loss_cnt 0, synchroniser flops 0, counters 0.
REQ-035 Reset mid-sequence SHALL override all transitions; sequence restarts from WAIT_LOCK.

Verification (NUM_CH=3, SYNC_STAGES=2, HOLD_CYCLES=8, IDLY_RST_CYCLES=4, RDY_TIMEOUT=32, STAGGER=2, SOFT_CYCLES=5)
REQ-036 pll_lock rises, idelay_rdy high -> HOLD 8 cycles, idelay_rst falls after IDLY_RST 4 cycles, ch_rst 3'b111->3'b110->3'b100->3'b000 two cycles apart, all_ready=1.
REQ-037 idelay_rdy held 0 -> timeout_err=1 after 32 WAIT_RDY cycles, channels still release, all_ready=1.
REQ-038 In RUN, soft_rst pulse with ch_mask=3'b101 -> ch_rst=3'b101 for SOFT 5 cycles, ch[0] then ch[2] clear 4 cycles apart, ch[1] stays 0.
REQ-039 pll_lock drops during RELEASE -> after SYNC_STAGES+1 edges ch_rst=3'b111, state=0, lock_loss_cnt=1; relock repeats REQ-036.
REQ-040 300 lock toggles -> lock_loss_cnt=255; sys_rst_n low one cycle -> all outputs per REQ-034.

Source files
------------

// File: rtl/infra_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : infra_reset_sequencer
// Purpose  : PLL-lock / IDELAYCTRL bring-up and staggered per-channel reset.
// Revision : 1.0 - initial release
// ============================================================================
module infra_reset_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int HOLD_CYCLES     = 65535,
  parameter int IDLY_RST_CYCLES = 16,
  parameter int RDY_TIMEOUT     = 4096,
  parameter int STAGGER         = 8,
  parameter int SOFT_CYCLES     = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_lock,
  input  logic              idelay_rdy,
  input  logic              soft_rst,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              idelay_rst,
  output logic              all_ready,
  output logic [2:0]        state,
  output logic              timeout_err,
  output logic [7:0]        lock_loss_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int REL_SPAN = (NUM_CH - 1) * STAGGER;
  localparam int CNT_MAX  = max2(max2(max2(HOLD_CYCLES, IDLY_RST_CYCLES),
                                      max2(RDY_TIMEOUT, SOFT_CYCLES)), REL_SPAN);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLY_LAST = CNT_W'(IDLY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_SPAN);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    IDLY_RST  = 3'd2,
    WAIT_RDY  = 3'd3,
    RELEASE   = 3'd4,
    RUN       = 3'd5,
    SOFT      = 3'd6
  } state_t;

  state_t                 cur_state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   lock_prev;
  logic                   lock_s;
  logic                   rdy_s;

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign rdy_s  = rdy_sync[SYNC_STAGES-1];
  assign state  = cur_state;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_sync     <= '0;
      rdy_sync      <= '0;
      lock_prev     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], idelay_rdy};
      lock_prev <= lock_s;
      if (lock_prev && !lock_s && (lock_loss_cnt != 8'hFF))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cur_state   <= WAIT_LOCK;
      cnt         <= '0;
      ch_rst      <= '1;
      idelay_rst  <= 1'b1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else if ((cur_state != WAIT_LOCK) && !lock_s) begin
      // Lock loss outranks every other transition, including soft requests.
      cur_state  <= WAIT_LOCK;
      cnt        <= '0;
      ch_rst     <= '1;
      idelay_rst <= 1'b1;
      all_ready  <= 1'b0;
    end else begin
      case (cur_state)
        WAIT_LOCK: begin
          ch_rst     <= '1;
          idelay_rst <= 1'b1;
          all_ready  <= 1'b0;
          cnt        <= '0;
          if (lock_s) cur_state <= HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            cur_state <= IDLY_RST;
          end else cnt <= cnt + 1'b1;
        end
        IDLY_RST: begin
          if (cnt == IDLY_LAST) begin
            cnt        <= '0;
            idelay_rst <= 1'b0;
            cur_state  <= WAIT_RDY;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            cnt       <= '0;
            cur_state <= RELEASE;
          end else if (cnt == RDY_LAST) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            cur_state   <= RELEASE;
          end else cnt <= cnt + 1'b1;
        end
        RELEASE: begin
          // Channels never asserted here are already 0, so clearing is harmless.
          for (int i = 0; i < NUM_CH; i++)
            if (cnt == CNT_W'(i * STAGGER)) ch_rst[i] <= 1'b0;
          if (cnt == REL_LAST) begin
            cnt       <= '0;
            all_ready <= 1'b1;
            cur_state <= RUN;
          end else cnt <= cnt + 1'b1;
        end
        RUN: begin
          if (soft_rst && (ch_mask != '0)) begin
            ch_rst    <= ch_rst | ch_mask;
            all_ready <= 1'b0;
            cnt       <= '0;
            cur_state <= SOFT;
          end
        end
        SOFT: begin
          if (cnt == SOFT_LAST) begin
            cnt       <= '0;
            cur_state <= RELEASE;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          cur_state  <= WAIT_LOCK;
          cnt        <= '0;
          ch_rst     <= '1;
          idelay_rst <= 1'b1;
          all_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
